// File: rtl/waveform_timer_ctrl_if.sv
// Handshake bundle between the waveform timer controller and its stream/datapath side.
// The master side drives the stream and handshakes; the slave side is the controller.
interface waveform_timer_ctrl_if;
  logic data;
  logic done_counting;
  logic ack;
  logic shift_ena;
  logic count_ena;
  logic done;
  logic timeout;
  logic busy;

  modport master (
    output data, done_counting, ack,
    input  shift_ena, count_ena, done, timeout, busy
  );

  modport slave (
    input  data, done_counting, ack,
    output shift_ena, count_ena, done, timeout, busy
  );
endinterface

// File: rtl/waveform_timer_ctrl.sv
// Control FSM for the waveform shift/count datapath: finds the start pattern,
// runs the shift and count phases, then waits for acknowledge.
module waveform_timer_ctrl #(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PATTERN   = 4'b1101,
  parameter int               SHIFT_LEN = 4,
  parameter int               TIMEOUT   = 0
) (
  input logic                  clk,
  input logic                  reset,
  waveform_timer_ctrl_if.slave ctrl
);

  localparam int HIST_W = PAT_W - 1;
  localparam int FILL_W = $clog2(PAT_W);
  localparam int SCNT_W = $clog2(SHIFT_LEN + 1);
  localparam int TCNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SHIFT_LEN - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_SHIFT,
    S_COUNT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                timeout_q, timeout_d;
  logic [PAT_W-1:0]    shifted;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_SEARCH;
      hist_q    <= '0;
      fill_q    <= '0;
      scnt_q    <= '0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      scnt_q    <= scnt_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  // History only evolves in SEARCH and is zeroed on leaving it, so every
  // re-entry starts from an empty history with no stale bits.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    scnt_d    = scnt_q;
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
    shifted   = {hist_q, ctrl.data};

    case (state_q)
      S_SEARCH: begin
        if (fill_q == FILL_MAX && shifted == PATTERN) begin
          state_d = S_SHIFT;
          scnt_d  = '0;
          hist_d  = '0;
          fill_d  = '0;
        end else begin
          hist_d = shifted[HIST_W-1:0];
          if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
      end

      S_SHIFT: begin
        if (scnt_q == SCNT_LAST) begin
          state_d = S_COUNT;
          tcnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end

      // done_counting wins over a timeout landing on the same edge.
      S_COUNT: begin
        if (ctrl.done_counting) begin
          state_d = S_DONE;
        end else if (TIMEOUT_EN && tcnt_q == TCNT_LAST) begin
          state_d   = S_SEARCH;
          timeout_d = 1'b1;
        end else if (TIMEOUT_EN) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      S_DONE: begin
        if (ctrl.ack) begin
          state_d = S_SEARCH;
        end
      end

      default: begin
        state_d = S_SEARCH;
      end
    endcase
  end

  assign ctrl.shift_ena = (state_q == S_SHIFT);
  assign ctrl.count_ena = (state_q == S_COUNT);
  assign ctrl.done      = (state_q == S_DONE);
  assign ctrl.timeout   = timeout_q;
  assign ctrl.busy      = (state_q != S_SEARCH);

endmodule
